// File: rtl/capture_block.sv
// capture_block: selects one of four 8-bit sample streams, optionally waits for a
// signed level trigger, decimates, packs four samples per 32-bit word and streams
// a programmed number of words out a valid/full interface. APB configured.
module capture_block #(
  parameter int unsigned DECIM_WIDTH = 16,
  parameter int unsigned LEN_WIDTH   = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        penable,
  input  logic        psel,
  input  logic [31:0] paddr,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  input  logic [7:0]  ina_data,
  input  logic [7:0]  inb_data,
  input  logic [7:0]  ddsa_data,
  input  logic [7:0]  ddsb_data,
  output logic [31:0] usb_wr_data,
  output logic        usb_wr_valid,
  input  logic        usb_wr_full
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StCapture = 2'd2,
    StDone    = 2'd3
  } state_e;

  logic [7:0]             addr;
  logic                   wr_en;
  logic                   arm;
  logic                   abort;
  logic                   unused_bits;

  logic [1:0]             src_q;
  logic                   trig_en_q;
  logic                   trig_fall_q;
  logic [7:0]             trig_level_q;
  logic [DECIM_WIDTH-1:0] decim_q;
  logic [LEN_WIDTH-1:0]   length_q;

  logic [7:0]             src_data;
  logic [7:0]             smp_q;
  logic [7:0]             prev_q;
  logic                   trig_hit;

  state_e                 state_q;
  logic [DECIM_WIDTH-1:0] dec_cnt_q;
  logic [23:0]            pack_q;
  logic [1:0]             idx_q;
  logic [LEN_WIDTH-1:0]   gen_q;
  logic [LEN_WIDTH-1:0]   count_q;
  logic                   ovf_q;
  logic [31:0]            data_q;
  logic                   valid_q;

  logic                   take;
  logic                   accept;
  logic                   gen_room;

  assign addr        = paddr[7:0];
  assign wr_en       = psel & penable & pwrite;
  assign arm         = wr_en && (addr == 8'h00) && pwdata[0];
  assign abort       = wr_en && (addr == 8'h00) && pwdata[1];
  assign unused_bits = ^{paddr[31:8], pwdata};

  assign take     = (dec_cnt_q == '0);
  assign accept   = valid_q & ~usb_wr_full;
  // Only words actually loaded count towards LENGTH; dropped words are regenerated.
  assign gen_room = (gen_q < length_q);

  assign usb_wr_data  = data_q;
  assign usb_wr_valid = valid_q;

  // APB configuration registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_q        <= 2'd0;
      trig_en_q    <= 1'b0;
      trig_fall_q  <= 1'b0;
      trig_level_q <= 8'd0;
      decim_q      <= '0;
      length_q     <= '0;
    end else if (wr_en) begin
      case (addr)
        8'h00: begin
          src_q       <= pwdata[3:2];
          trig_en_q   <= pwdata[4];
          trig_fall_q <= pwdata[5];
        end
        8'h04:   trig_level_q <= pwdata[7:0];
        8'h08:   decim_q      <= pwdata[DECIM_WIDTH-1:0];
        8'h0C:   length_q     <= pwdata[LEN_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  // APB read mux, combinational and zero when not selected
  always_comb begin
    prdata = 32'd0;
    if (psel) begin
      case (addr)
        8'h00:   prdata = {26'd0, trig_fall_q, trig_en_q, src_q, 2'b00};
        8'h04:   prdata = {24'd0, trig_level_q};
        8'h08:   prdata = 32'(decim_q);
        8'h0C:   prdata = 32'(length_q);
        8'h10:   prdata = {29'd0, ovf_q, state_q};
        8'h14:   prdata = 32'(count_q);
        default: prdata = 32'd0;
      endcase
    end
  end

  // Source select
  always_comb begin
    unique case (src_q)
      2'd0: src_data = ina_data;
      2'd1: src_data = inb_data;
      2'd2: src_data = ddsa_data;
      2'd3: src_data = ddsb_data;
    endcase
  end

  // Sample register and one-sample history for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      smp_q  <= 8'd0;
      prev_q <= 8'd0;
    end else begin
      smp_q  <= src_data;
      prev_q <= smp_q;
    end
  end

  // Signed level crossing in the selected direction
  always_comb begin
    if (trig_fall_q) begin
      trig_hit = ($signed(prev_q) >= $signed(trig_level_q)) &&
                 ($signed(smp_q) < $signed(trig_level_q));
    end else begin
      trig_hit = ($signed(prev_q) < $signed(trig_level_q)) &&
                 ($signed(smp_q) >= $signed(trig_level_q));
    end
  end

  // Capture FSM with decimator, packer and registered output word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      dec_cnt_q <= '0;
      pack_q    <= 24'd0;
      idx_q     <= 2'd0;
      gen_q     <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      data_q    <= 32'd0;
      valid_q   <= 1'b0;
    end else if (abort) begin
      state_q <= StIdle;
      valid_q <= 1'b0;
      pack_q  <= 24'd0;
      idx_q   <= 2'd0;
    end else begin
      if (accept) begin
        valid_q <= 1'b0;
      end
      unique case (state_q)
        StIdle, StDone: begin
          valid_q <= 1'b0;
          if (arm) begin
            count_q   <= '0;
            gen_q     <= '0;
            ovf_q     <= 1'b0;
            pack_q    <= 24'd0;
            idx_q     <= 2'd0;
            dec_cnt_q <= '0;
            state_q   <= (length_q == '0) ? StDone : StArmed;
          end
        end
        StArmed: begin
          if (!trig_en_q) begin
            dec_cnt_q <= '0;
            state_q   <= StCapture;
          end else if (trig_hit) begin
            // Trigger sample is the first captured sample; decimator restarts here.
            pack_q[7:0] <= smp_q;
            idx_q       <= 2'd1;
            dec_cnt_q   <= decim_q;
            state_q     <= StCapture;
          end
        end
        StCapture: begin
          if (take) begin
            dec_cnt_q <= decim_q;
          end else begin
            dec_cnt_q <= dec_cnt_q - DECIM_WIDTH'(1);
          end
          if (take && gen_room) begin
            unique case (idx_q)
              2'd0: pack_q[7:0]   <= smp_q;
              2'd1: pack_q[15:8]  <= smp_q;
              2'd2: pack_q[23:16] <= smp_q;
              2'd3: begin
                pack_q <= 24'd0;
                if (valid_q && usb_wr_full) begin
                  ovf_q <= 1'b1;
                end else begin
                  data_q  <= {smp_q, pack_q};
                  valid_q <= 1'b1;
                  gen_q   <= gen_q + LEN_WIDTH'(1);
                end
              end
            endcase
            idx_q <= idx_q + 2'd1;
          end
          if (accept) begin
            count_q <= count_q + LEN_WIDTH'(1);
            if (count_q + LEN_WIDTH'(1) >= length_q) begin
              state_q <= StDone;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_capture_block.sv
// Directed bench for capture_block: register table plus hand-built capture sequences.
module tb_capture_block;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        penable = 1'b0;
  logic        psel = 1'b0;
  logic [31:0] paddr = 32'd0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = 32'd0;
  logic [31:0] prdata;
  logic [7:0]  ina_data = 8'd0;
  logic [7:0]  inb_data = 8'd0;
  logic [7:0]  ddsa_data = 8'd0;
  logic [7:0]  ddsb_data = 8'd0;
  logic [31:0] usb_wr_data;
  logic        usb_wr_valid;
  logic        usb_wr_full = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  ramp_val = 8'd0;
  logic [7:0]  ramp_step = 8'd1;
  logic        ramp_on = 1'b0;
  int          word_base = 0;

  logic [31:0] words[$];
  int          valid_cycles = 0;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } reg_vec_t;

  reg_vec_t vecs[13];

  always #5 clk = ~clk;

  capture_block dut (
    .clk         (clk),
    .reset       (reset),
    .penable     (penable),
    .psel        (psel),
    .paddr       (paddr),
    .pwrite      (pwrite),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .ina_data    (ina_data),
    .inb_data    (inb_data),
    .ddsa_data   (ddsa_data),
    .ddsb_data   (ddsb_data),
    .usb_wr_data (usb_wr_data),
    .usb_wr_valid(usb_wr_valid),
    .usb_wr_full (usb_wr_full)
  );

  // Record every word that transfers (valid && !full) on the following edge.
  always @(negedge clk) begin
    if (usb_wr_valid) valid_cycles++;
    if (usb_wr_valid && !usb_wr_full) words.push_back(usb_wr_data);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_word(input string name, input int idx, input logic [31:0] exp);
    if (idx < words.size()) begin
      check(name, words[idx], exp);
    end else begin
      n_vec++;
      n_err++;
      $display("FAIL %s: got no word, want 0x%08h", name, exp);
    end
  endtask

  task automatic drive_src();
    ina_data  = ramp_val;
    inb_data  = ramp_val + 8'h40;
    ddsa_data = ramp_val + 8'h80;
    ddsb_data = ramp_val + 8'hC0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (ramp_on) ramp_val = ramp_val + ramp_step;
    drive_src();
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    psel    = 1'b1;
    pwrite  = 1'b1;
    penable = 1'b0;
    paddr   = {24'd0, a};
    pwdata  = d;
    @(posedge clk);
    #1;
    penable = 1'b1;
    @(posedge clk);
    #1;
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
    psel    = 1'b1;
    pwrite  = 1'b0;
    penable = 1'b0;
    paddr   = {24'd0, a};
    @(negedge clk);
    d    = prdata;
    psel = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    apb_read(a, d);
    check(name, d, exp);
  endtask

  // Ramp value is held steady through the arm write, then advances once per cycle.
  task automatic arm_run(input logic [31:0] ctrl, input logic [7:0] start,
                         input logic [7:0] step);
    ramp_on   = 1'b0;
    ramp_val  = start;
    ramp_step = step;
    drive_src();
    word_base = words.size();
    apb_write(8'h00, ctrl | 32'h1);
    ramp_on = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, want finish before 400000ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    int          bad;
    int          seen;
    int          vc0;

    vecs[0]  = '{1'b0, 8'h00, 32'h0,        32'h0};
    vecs[1]  = '{1'b0, 8'h04, 32'h0,        32'h0};
    vecs[2]  = '{1'b0, 8'h08, 32'h0,        32'h0};
    vecs[3]  = '{1'b0, 8'h0C, 32'h0,        32'h0};
    vecs[4]  = '{1'b0, 8'h10, 32'h0,        32'h0};
    vecs[5]  = '{1'b0, 8'h14, 32'h0,        32'h0};
    vecs[6]  = '{1'b1, 8'h00, 32'h0000003C, 32'h0000003C};
    vecs[7]  = '{1'b1, 8'h00, 32'hFFFFFFDC, 32'h0000001C};
    vecs[8]  = '{1'b1, 8'h04, 32'hFFFFFF85, 32'h00000085};
    vecs[9]  = '{1'b1, 8'h08, 32'hABCD1234, 32'h00001234};
    vecs[10] = '{1'b1, 8'h0C, 32'hFF123456, 32'h00123456};
    vecs[11] = '{1'b0, 8'h18, 32'h0,        32'h0};
    vecs[12] = '{1'b0, 8'h10, 32'h0,        32'h0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, usb_wr_valid}, 32'd0);
    check("rst_data", usb_wr_data, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Register table
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].wr) apb_write(vecs[i].addr, vecs[i].wdata);
      apb_read(vecs[i].addr, d);
      check($sformatf("reg_vec%0d", i), d, vecs[i].exp);
    end
    paddr = 32'h08;
    psel  = 1'b0;
    #1;
    check("prdata_no_psel", prdata, 32'd0);

    // Free run: src 0, no trigger, DECIM 0, LENGTH 2
    apb_write(8'h08, 32'd0);
    apb_write(8'h0C, 32'd2);
    arm_run(32'h00, 8'h00, 8'h01);
    run_ticks(16);
    check_word("free_word0", word_base, 32'h03020100);
    check_word("free_word1", word_base + 1, 32'h07060504);
    check("free_nwords", 32'(words.size() - word_base), 32'd2);
    read_check("free_status", 8'h10, 32'h3);
    read_check("free_count", 8'h14, 32'd2);

    // Source select: ddsb
    apb_write(8'h0C, 32'd1);
    arm_run(32'h0C, 8'h00, 8'h01);
    run_ticks(12);
    check_word("src3_word", word_base, 32'hC3C2C1C0);

    // Rising trigger at level 10
    apb_write(8'h04, 32'd10);
    arm_run(32'h10, 8'h00, 8'h01);
    run_ticks(24);
    check_word("rise_word", word_base, 32'h0D0C0B0A);
    read_check("rise_status", 8'h10, 32'h3);

    // Falling trigger through signed zero
    apb_write(8'h04, 32'd0);
    arm_run(32'h30, 8'h03, 8'hFF);
    run_ticks(16);
    check_word("fall_word", word_base, 32'hFCFDFEFF);

    // Decimation by 3
    apb_write(8'h08, 32'd2);
    arm_run(32'h00, 8'h00, 8'h01);
    run_ticks(20);
    check_word("decim_word", word_base, 32'h09060300);
    apb_write(8'h08, 32'd0);

    // Backpressure: first word held while full, later words dropped
    apb_write(8'h0C, 32'd3);
    usb_wr_full = 1'b1;
    arm_run(32'h00, 8'h00, 8'h01);
    bad  = 0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (usb_wr_valid) begin
        seen++;
        if (usb_wr_data !== 32'h03020100) bad++;
      end
    end
    check("bp_valid_held", {31'd0, usb_wr_valid}, 32'd1);
    check("bp_held_seen", {31'd0, (seen > 0)}, 32'd1);
    check("bp_word_unstable_cycles", 32'(bad), 32'd0);
    read_check("bp_status_ovf", 8'h10, 32'h6);
    tick();
    usb_wr_full = 1'b0;
    tick();
    read_check("bp_count_after_release", 8'h14, 32'd1);
    run_ticks(30);
    check_word("bp_first_word", word_base, 32'h03020100);
    check("bp_nwords", 32'(words.size() - word_base), 32'd3);
    read_check("bp_status_done", 8'h10, 32'h7);
    read_check("bp_count_done", 8'h14, 32'd3);

    // Abort at COUNT=1 with a word pending
    arm_run(32'h00, 8'h50, 8'h01);
    d = 32'd0;
    for (int i = 0; i < 40 && d != 32'd1; i++) apb_read(8'h14, d);
    check("abort_count_reached", d, 32'd1);
    tick();
    usb_wr_full = 1'b1;
    for (int i = 0; i < 10 && !usb_wr_valid; i++) tick();
    check("abort_pre_valid", {31'd0, usb_wr_valid}, 32'd1);
    apb_write(8'h00, 32'h2);
    check("abort_valid_drop", {31'd0, usb_wr_valid}, 32'd0);
    apb_read(8'h10, d);
    check("abort_state", d & 32'h3, 32'h0);
    read_check("abort_count_kept", 8'h14, 32'd1);
    tick();
    usb_wr_full = 1'b0;
    vc0 = valid_cycles;
    run_ticks(8);
    check("abort_idle_quiet", 32'(valid_cycles - vc0), 32'd0);

    // Re-arm after abort starts from an empty packer
    apb_write(8'h0C, 32'd1);
    arm_run(32'h00, 8'h20, 8'h01);
    run_ticks(12);
    check_word("rearm_word", word_base, 32'h23222120);
    read_check("rearm_count", 8'h14, 32'd1);

    // LENGTH=0 goes straight to DONE with no output
    apb_write(8'h0C, 32'd0);
    vc0 = valid_cycles;
    apb_write(8'h00, 32'h1);
    read_check("len0_status", 8'h10, 32'h3);
    run_ticks(8);
    check("len0_no_valid", 32'(valid_cycles - vc0), 32'd0);
    read_check("len0_count", 8'h14, 32'd0);

    // Asynchronous reset in the middle of a capture
    apb_write(8'h0C, 32'd4);
    arm_run(32'h00, 8'h60, 8'h01);
    run_ticks(7);
    read_check("rst_pre_count", 8'h14, 32'd1);
    tick();
    usb_wr_full = 1'b1;
    run_ticks(3);
    check("rst_pre_valid", {31'd0, usb_wr_valid}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_valid", {31'd0, usb_wr_valid}, 32'd0);
    check("arst_data", usb_wr_data, 32'd0);
    psel   = 1'b1;
    pwrite = 1'b0;
    paddr  = 32'h10;
    #1;
    check("arst_status", prdata, 32'd0);
    paddr = 32'h14;
    #1;
    check("arst_count", prdata, 32'd0);
    paddr = 32'h00;
    #1;
    check("arst_ctrl", prdata, 32'd0);
    psel        = 1'b0;
    usb_wr_full = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
